draw_hook_gen: RTL and testbench
================================

DRAW_HOOK_GEN -- requirements
Module: draw_hook_gen

Interface
REQ-001 SHALL have parameters as follows (name, default, meaning):
  X_W, 9, pixel X width
  Y_W, 8, pixel Y width
  COLOR_W, 12, color width
  ANCHOR_X, 160, rope origin X
  ANCHOR_Y, 45, rope origin Y
  ROPE_STEPS, 64, rope segments (power of 2, 2..256)
  RADIUS, 20, hook radius in pixels
  GAP_DEG, 40, claw opening in degrees
  DEG_STEP, 5, arc step (divides 360)
  HOOK_COLOR, 12'hBBB, draw color
  BG_COLOR, 12'h000, erase color
REQ-002 SHALL have ports as follows (name, direction, width, meaning):
  clock, in, 1, clock
  resetn, in, 1, reset
  start, in, 1, begin a figure
  erase, in, 1, draw in BG_COLOR
  length, in, 10, rope length in pixels
  degree, in, 9, swing angle in degrees
  pix_ready, in, 1, sink accepts pixel
  pix_x, out, X_W, pixel X
  pix_y, out, Y_W, pixel Y
  pix_color, out, COLOR_W, pixel color
  pix_valid, out, 1, pixel offered
  busy, out, 1, figure in progress
  done, out, 1, one-cycle completion pulse
REQ-003 Reset resetn, synchronous, active-low; clock clock.

Function
REQ-004 FSM states IDLE, SETUP, ROPE, HOOK, DONE; IDLE->SETUP on start, SETUP->ROPE after 1 cycle, ROPE->HOOK after last rope point, HOOK->DONE after last arc angle, DONE->IDLE after 1 cycle.
REQ-005 In IDLE, start latches length, erase and degree (degree>=360 reduced by 360); start is ignored in every other state.
REQ-006 busy SHALL be 1 in SETUP, ROPE, HOOK and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-007 Trig: internal LUT of 91 entries, sin 0..90 deg, round(100*sin); other quadrants folded with a separate sign bit; no external trig module.
REQ-008 SETUP computes tip: tipX = ANCHOR_X + length*cos(t)/100, tipY = ANCHOR_Y + length*sin(t)/100, with t = degree + GAP_DEG/2 (mod 360); signed 13-bit, truncated toward zero.
REQ-009 ROPE emits points k = 0..ROPE_STEPS at anchor + (tip-anchor)*k/ROPE_STEPS, truncated toward zero.
REQ-010 HOOK visits a = 0, DEG_STEP, ... < 360 at (tipX + RADIUS*cos(a)/100, tipY + RADIUS*sin(a)/100).
REQ-011 In HOOK, angle a SHALL be skipped when inside the closed gap [degree, degree+GAP_DEG] mod 360, including wrap past 359.
REQ-012 Any point with coordinate <0, X>=2^X_W or Y>=2^Y_W SHALL be skipped.
REQ-013 A skipped point consumes exactly one cycle with pix_valid=0.
REQ-014 Handshake: a point transfers on pix_valid&&pix_ready; pix_x/pix_y/pix_color SHALL stay stable while pix_valid&&!pix_ready; pix_valid SHALL never drop without a transfer except on reset.
REQ-015 With pix_ready held 1, one point SHALL be issued or skipped per cycle; outputs are registered.
REQ-016 pix_color = BG_COLOR if latched erase, else HOOK_COLOR.

Reset
REQ-017 On resetn=0 at a clock edge, state=IDLE, pix_valid=0, busy=0, done=0, pix_x=0, pix_y=0, pix_color=0, latched inputs=0; this applies mid-figure and outranks start.

Verification
REQ-018 degree=0, length=100, ready=1, start pulse -> tip (254,79); first rope pixel (160,45), 65th (254,79); 63 hook pixels; first hook pixel at a=45 is (268,93); done once; 128 transfers total.
REQ-019 pix_ready=0 for 3 cycles mid-ROPE -> pix_x/pix_y/pix_valid unchanged for those 3 cycles, no point lost or duplicated.
REQ-020 degree=340 -> hook angles 340..355 and 0..20 produce no pix_valid; angle 25 does.
REQ-021 degree=180, length=200 -> tipX=-28; no pix_valid with negative x; FSM still reaches DONE.
REQ-022 erase=1 at start, then erase=0 mid-figure -> every pixel BG_COLOR.
REQ-023 resetn=0 for one cycle in HOOK -> next cycle IDLE, pix_valid=0, busy=0, no done pulse; start during busy ignored.

Source files
------------

// File: rtl/draw_hook_gen.sv
// draw_hook_gen: streams the pixels of a crane rope and an open claw hook.
// A figure runs SETUP (tip position), ROPE (straight line from the anchor to
// the tip) and HOOK (circle around the tip with a gap for the claw opening).
// Every rope point or arc angle takes exactly one issue slot. A point that is
// off screen or in the claw gap uses its slot with pix_valid low. The pixel
// register holds its value until the sink takes it.
module draw_hook_gen #(
  parameter int                 X_W        = 9,
  parameter int                 Y_W        = 8,
  parameter int                 COLOR_W    = 12,
  parameter int                 ANCHOR_X   = 160,
  parameter int                 ANCHOR_Y   = 45,
  parameter int                 ROPE_STEPS = 64,
  parameter int                 RADIUS     = 20,
  parameter int                 GAP_DEG    = 40,
  parameter int                 DEG_STEP   = 5,
  parameter logic [COLOR_W-1:0] HOOK_COLOR = 12'hBBB,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               erase,
  input  logic [9:0]         length,
  input  logic [8:0]         degree,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, SETUP, ROPE, HOOK, DONE} state_t;

  // The counter must hold ROPE_STEPS itself, because the rope has
  // ROPE_STEPS+1 points.
  localparam int K_W = $clog2(ROPE_STEPS + 1);

  // round(100*sin(d)) for d = 0..90. The other quadrants are folded onto this
  // table and the sign is applied separately.
  localparam int SIN_LUT [0:90] = '{
      0,   2,   3,   5,   7,   9,  10,  12,  14,  16,
     17,  19,  21,  22,  24,  26,  28,  29,  31,  33,
     34,  36,  37,  39,  41,  42,  44,  45,  47,  48,
     50,  52,  53,  54,  56,  57,  59,  60,  62,  63,
     64,  66,  67,  68,  69,  71,  72,  73,  74,  75,
     77,  78,  79,  80,  81,  82,  83,  84,  85,  86,
     87,  87,  88,  89,  90,  91,  91,  92,  93,  93,
     94,  95,  95,  96,  96,  97,  97,  97,  98,  98,
     98,  99,  99,  99,  99, 100, 100, 100, 100, 100,
    100
  };

  // Returns 100*sin(ang) for ang in 0..359. The magnitude comes from the
  // quarter-wave table and the sign is added afterwards.
  function automatic logic signed [7:0] sin100(input logic [8:0] ang);
    logic [6:0] fold;
    logic       neg;
    logic [7:0] mag;
    fold = 7'd0;
    neg  = 1'b0;
    if (ang <= 9'd90) begin
      fold = ang[6:0];
    end else if (ang <= 9'd180) begin
      fold = 7'(9'd180 - ang);
    end else if (ang <= 9'd270) begin
      fold = 7'(ang - 9'd180);
      neg  = 1'b1;
    end else begin
      fold = 7'(9'd360 - ang);
      neg  = 1'b1;
    end
    mag = 8'(SIN_LUT[fold]);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // Returns (ang + 90) mod 360. This lets the sine table also give the cosine.
  function automatic logic [8:0] plus90(input logic [8:0] ang);
    return (ang >= 9'd270) ? 9'(ang - 9'd270) : 9'(ang + 9'd90);
  endfunction

  state_t               state_q, state_d;
  logic [9:0]           length_q, length_d;
  logic [8:0]           degree_q, degree_d;
  logic                 erase_q, erase_d;
  logic signed [12:0]   tip_x_q, tip_x_d;
  logic signed [12:0]   tip_y_q, tip_y_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [8:0]           a_q, a_d;
  logic [X_W-1:0]       pix_x_q, pix_x_d;
  logic [Y_W-1:0]       pix_y_q, pix_y_d;
  logic [COLOR_W-1:0]   pix_color_q, pix_color_d;
  logic                 pix_valid_q, pix_valid_d;

  logic [9:0]           t_sum;
  logic [8:0]           t_ang;
  logic [8:0]           trig_ang;
  logic signed [7:0]    sin_v;
  logic signed [7:0]    cos_v;
  int                   tip_x_calc, tip_y_calc;
  int                   pt_x, pt_y;
  int                   gap_diff;
  logic                 in_gap;
  logic                 on_screen;
  logic                 pt_visible;
  logic                 advance;
  logic                 last_rope;
  logic                 last_angle;

  // A new point may be issued when the pixel register is empty or is being
  // taken by the sink on this edge.
  assign advance    = !pix_valid_q || pix_ready;
  assign last_rope  = (k_q == K_W'(ROPE_STEPS));
  assign last_angle = (a_q == 9'(360 - DEG_STEP));

  // The trig unit is shared. SETUP uses it for the tip angle and HOOK uses it
  // for the current arc angle.
  always_comb begin
    t_sum    = {1'b0, degree_q} + 10'(GAP_DEG / 2);
    t_ang    = (t_sum >= 10'd360) ? 9'(t_sum - 10'd360) : t_sum[8:0];
    trig_ang = (state_q == SETUP) ? t_ang : a_q;
    sin_v    = sin100(trig_ang);
    cos_v    = sin100(plus90(trig_ang));
  end

  // Geometry for the current slot: the tip, the rope or arc point, and
  // whether that point is drawn or skipped. Signed division truncates
  // toward zero.
  always_comb begin
    tip_x_calc = ANCHOR_X + (int'(length_q) * int'(cos_v)) / 100;
    tip_y_calc = ANCHOR_Y + (int'(length_q) * int'(sin_v)) / 100;
    if (state_q == ROPE) begin
      pt_x = ANCHOR_X + ((int'(tip_x_q) - ANCHOR_X) * int'(k_q)) / ROPE_STEPS;
      pt_y = ANCHOR_Y + ((int'(tip_y_q) - ANCHOR_Y) * int'(k_q)) / ROPE_STEPS;
    end else begin
      pt_x = int'(tip_x_q) + (RADIUS * int'(cos_v)) / 100;
      pt_y = int'(tip_y_q) + (RADIUS * int'(sin_v)) / 100;
    end
    // The distance from the claw start, measured forward and wrapped, puts
    // the gap [degree, degree+GAP_DEG] into one range that is easy to test.
    gap_diff = int'(a_q) - int'(degree_q);
    if (gap_diff < 0) begin
      gap_diff = gap_diff + 360;
    end
    in_gap     = (state_q == HOOK) && (gap_diff <= GAP_DEG);
    on_screen  = (pt_x >= 0) && (pt_x < (1 << X_W)) &&
                 (pt_y >= 0) && (pt_y < (1 << Y_W));
    pt_visible = on_screen && !in_gap;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. ROPE and HOOK move on only in a slot where the last
  // point is actually issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = ROPE;
      ROPE:    if (advance && last_rope) state_d = HOOK;
      HOOK:    if (advance && last_angle) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next state: latch the command, set up the tip, step the
  // iterators and fill the pixel register.
  always_comb begin
    length_d    = length_q;
    degree_d    = degree_q;
    erase_d     = erase_q;
    tip_x_d     = tip_x_q;
    tip_y_d     = tip_y_q;
    k_d         = k_q;
    a_d         = a_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_valid_d = pix_valid_q;

    if (state_q == IDLE && start) begin
      length_d = length;
      erase_d  = erase;
      degree_d = (degree >= 9'd360) ? 9'(degree - 9'd360) : degree;
    end

    if (state_q == SETUP) begin
      tip_x_d = 13'(tip_x_calc);
      tip_y_d = 13'(tip_y_calc);
      k_d     = '0;
      a_d     = '0;
    end

    // The pending pixel is gone once the sink has taken it.
    if (pix_valid_q && pix_ready) begin
      pix_valid_d = 1'b0;
    end

    if ((state_q == ROPE || state_q == HOOK) && advance) begin
      pix_valid_d = pt_visible;
      if (pt_visible) begin
        pix_x_d     = pt_x[X_W-1:0];
        pix_y_d     = pt_y[Y_W-1:0];
        pix_color_d = erase_q ? BG_COLOR : HOOK_COLOR;
      end
      if (state_q == ROPE && !last_rope) begin
        k_d = k_q + K_W'(1);
      end
      if (state_q == HOOK && !last_angle) begin
        a_d = a_q + 9'(DEG_STEP);
      end
    end
  end

  // Datapath registers. Reset clears everything, even in the middle of a figure.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      length_q    <= '0;
      degree_q    <= '0;
      erase_q     <= 1'b0;
      tip_x_q     <= '0;
      tip_y_q     <= '0;
      k_q         <= '0;
      a_q         <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      length_q    <= length_d;
      degree_q    <= degree_d;
      erase_q     <= erase_d;
      tip_x_q     <= tip_x_d;
      tip_y_q     <= tip_y_d;
      k_q         <= k_d;
      a_q         <= a_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_draw_hook_gen.sv
// Directed bench for draw_hook_gen. It logs every pixel transfer and checks
// the log against rope and hook points worked out by hand.
`timescale 1ns/1ps
module tb_draw_hook_gen;

  logic        clock     = 1'b0;
  logic        resetn    = 1'b0;
  logic        start     = 1'b0;
  logic        erase     = 1'b0;
  logic [9:0]  length    = '0;
  logic [8:0]  degree    = '0;
  logic        pix_ready = 1'b1;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [11:0] pix_color;
  logic        pix_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int qx[$];
  int qy[$];
  int qc[$];
  int done_cnt = 0;
  int busy_cnt = 0;

  always #5 clock = ~clock;

  draw_hook_gen dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .erase     (erase),
    .length    (length),
    .degree    (degree),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done)
  );

  // Transfer log, sampled on the falling edge
  always @(negedge clock) begin
    if (resetn && pix_valid && pix_ready) begin
      qx.push_back(int'(pix_x));
      qy.push_back(int'(pix_y));
      qc.push_back(int'(pix_color));
    end
    if (resetn && done) done_cnt++;
    if (resetn && busy) busy_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int at_x(input int i);
    return (i < qx.size()) ? qx[i] : -1;
  endfunction

  function automatic int at_y(input int i);
    return (i < qy.size()) ? qy[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    qx.delete();
    qy.delete();
    qc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic launch(input int deg, input int len, input logic er);
    degree = 9'(deg);
    length = 10'(len);
    erase  = er;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check_val("figure ends", n < 1000, 1);
    tick();
  endtask

  task automatic wait_xfers(input int target);
    int n;
    for (n = 0; n < 500; n++) begin
      if (qx.size() >= target) break;
      tick();
    end
    check_val("xfer wait", qx.size() >= target, 1);
  endtask

  // Rope for the degree=0, length=100 figure. The tip is (254,79), so
  // dx=94 and dy=34.
  task automatic check_rope0(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k <= 64; k++) begin
      if (at_x(k) != 160 + (94 * k) / 64 || at_y(k) != 45 + (34 * k) / 64) bad++;
    end
    check_val(tag, bad, 0);
  endtask

  initial begin
    int sx, sy, bad, maxx, expx;

    // Reset state
    repeat (3) tick();
    check_val("rst valid", pix_valid, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst x", pix_x, 0);
    check_val("rst y", pix_y, 0);
    check_val("rst color", pix_color, 0);
    resetn = 1'b1;
    tick();

    // Basic figure. A second start in the middle of the figure must be ignored.
    clear_log();
    launch(0, 100, 1'b0);
    check_val("A busy in setup", busy, 1);
    repeat (20) tick();
    degree = 9'd90;
    length = 10'd50;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_idle();
    check_val("A total", qx.size(), 128);
    check_rope0("A rope seq");
    check_val("A rope0 x", at_x(0), 160);
    check_val("A rope0 y", at_y(0), 45);
    check_val("A rope32 x", at_x(32), 207);
    check_val("A rope32 y", at_y(32), 62);
    check_val("A tip x", at_x(64), 254);
    check_val("A tip y", at_y(64), 79);
    check_val("A hook45 x", at_x(65), 268);
    check_val("A hook45 y", at_y(65), 93);
    check_val("A hook355 x", at_x(127), 274);
    check_val("A hook355 y", at_y(127), 78);
    check_val("A done pulses", done_cnt, 1);
    check_val("A busy cycles", busy_cnt, 139);
    check_val("A idle busy", busy, 0);
    bad = 0;
    foreach (qc[i]) if (qc[i] != 'hBBB) bad++;
    check_val("A colors", bad, 0);

    // Sink stalls for 3 cycles during ROPE
    clear_log();
    launch(0, 100, 1'b0);
    wait_xfers(10);
    expx = 160 + (94 * qx.size()) / 64;
    pix_ready = 1'b0;
    @(negedge clock);
    sx = int'(pix_x);
    sy = int'(pix_y);
    check_val("B stall valid", pix_valid, 1);
    check_val("B stall point", sx, expx);
    for (int i = 1; i < 3; i++) begin
      @(negedge clock);
      check_val("B hold valid", pix_valid, 1);
      check_val("B hold x", pix_x, sx);
      check_val("B hold y", pix_y, sy);
    end
    @(posedge clock);
    #1;
    pix_ready = 1'b1;
    wait_idle();
    check_val("B total", qx.size(), 128);
    check_rope0("B rope seq");
    check_val("B busy cycles", busy_cnt, 142);

    // Claw gap wraps past 359: 340..355 and 0..20 are skipped, 25 is drawn
    clear_log();
    launch(340, 100, 1'b0);
    wait_idle();
    check_val("C total", qx.size(), 128);
    check_val("C tip x", at_x(64), 260);
    check_val("C tip y", at_y(64), 45);
    check_val("C hook25 x", at_x(65), 278);
    check_val("C hook25 y", at_y(65), 53);
    check_val("C hook335 x", at_x(127), 278);
    check_val("C hook335 y", at_y(127), 37);
    check_val("C done pulses", done_cnt, 1);

    // Figure partly off screen. The tip is (-28,-23). The rope leaves the
    // screen after k=43 at (34,0), and the whole hook is skipped.
    clear_log();
    launch(180, 200, 1'b0);
    wait_idle();
    check_val("D total", qx.size(), 44);
    check_val("D last x", at_x(43), 34);
    check_val("D last y", at_y(43), 0);
    maxx = 0;
    foreach (qx[i]) if (qx[i] > maxx) maxx = qx[i];
    check_val("D max x", maxx, 160);
    check_val("D done pulses", done_cnt, 1);

    // degree 380 becomes 20, so the tip angle is 40
    clear_log();
    launch(380, 100, 1'b0);
    wait_idle();
    check_val("E total", qx.size(), 128);
    check_val("E tip x", at_x(64), 237);
    check_val("E tip y", at_y(64), 109);
    check_val("E hook0 x", at_x(65), 257);
    check_val("E hook0 y", at_y(65), 109);
    check_val("E hook355 y", at_y(127), 108);

    // Erase is latched at start. Dropping it later must not change the color.
    clear_log();
    launch(0, 100, 1'b1);
    repeat (5) tick();
    erase = 1'b0;
    wait_idle();
    check_val("F total", qx.size(), 128);
    bad = 0;
    foreach (qc[i]) if (qc[i] != 0) bad++;
    check_val("F colors", bad, 0);

    // Reset during HOOK, with start held high at the same time
    clear_log();
    launch(0, 100, 1'b0);
    wait_xfers(70);
    resetn = 1'b0;
    start  = 1'b1;
    tick();
    check_val("G valid", pix_valid, 0);
    check_val("G busy", busy, 0);
    check_val("G done", done, 0);
    check_val("G x", pix_x, 0);
    check_val("G y", pix_y, 0);
    check_val("G color", pix_color, 0);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (10) tick();
    check_val("G no done", done_cnt, 0);
    check_val("G stays idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
